// File: rtl/tug_match_ctrl.sv
// Tug-of-war match controller: push arbitration, light movement, scoring, pause/recentre, game over; CPU_LFSR_EN swaps cpuPress for an LFSR CPU.
// Latency: CPU push moves the light on the sampling edge, key push two edges after first sample; no backpressure, pushes outside PLAY are dropped.
module tug_match_ctrl #(
    parameter int NUM_LIGHTS   = 9,
    parameter int WIN_TARGET   = 7,
    parameter int PAUSE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  hardReset_n,
    input  logic                  start,
    input  logic                  playerKey,
    input  logic                  cpuPress,
    input  logic [8:0]            difficulty,
    output logic [NUM_LIGHTS-1:0] leds,
    output logic                  playerPoint,
    output logic                  cpuPoint,
    output logic [2:0]            playerScore,
    output logic [2:0]            cpuScore,
    output logic                  gameOver,
    output logic                  winner
);

    localparam int PW = $clog2(NUM_LIGHTS);
    localparam int CW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [PW-1:0] CENTER = PW'((NUM_LIGHTS - 1) / 2);
    localparam logic [PW-1:0] LAST   = PW'(NUM_LIGHTS - 1);
    localparam logic [2:0]    WIN    = 3'(WIN_TARGET);
    localparam logic [CW-1:0] CNT_END = CW'(PAUSE_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_PLAY, S_POINT, S_PAUSE, S_GAMEOVER} state_t;

    function automatic logic [NUM_LIGHTS-1:0] onehot(input logic [PW-1:0] p);
        onehot = {{(NUM_LIGHTS-1){1'b0}}, 1'b1} << p;
    endfunction

    state_t              r_state;
    logic [PW-1:0]       r_pos;
    logic [CW-1:0]       r_cnt;
    logic                r_sync1, r_sync2, r_key_d;
    logic                w_pp, w_pc;
    logic [PW-1:0]       w_pos_next;
    logic                w_p_pt, w_c_pt;

    always_ff @(posedge clk or negedge hardReset_n) begin
        if (!hardReset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_key_d <= 1'b0;
        end else begin
            r_sync1 <= playerKey;
            r_sync2 <= r_sync1;
            r_key_d <= r_sync2;
        end
    end

    // Edge detect runs in every state, so a press seen outside PLAY is consumed.
    assign w_pp = r_sync2 & ~r_key_d;

`ifdef CPU_LFSR_EN
    logic [9:0] r_lfsr;
    logic       w_unused_cpu;
    assign w_unused_cpu = cpuPress;

    always_ff @(posedge clk or negedge hardReset_n) begin
        if (!hardReset_n) r_lfsr <= 10'h001;
        else              r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    end

    assign w_pc = (r_lfsr < {1'b0, difficulty});
`else
    logic w_unused_diff;
    assign w_unused_diff = ^difficulty;
    assign w_pc = cpuPress;
`endif

    always_comb begin
        w_pos_next = r_pos;
        w_p_pt     = 1'b0;
        w_c_pt     = 1'b0;
        if (w_pp && !w_pc) begin
            if (r_pos == '0) w_p_pt = 1'b1;
            else             w_pos_next = r_pos - PW'(1);
        end else if (w_pc && !w_pp) begin
            if (r_pos == LAST) w_c_pt = 1'b1;
            else               w_pos_next = r_pos + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge hardReset_n) begin
        if (!hardReset_n) begin
            r_state     <= S_IDLE;
            r_pos       <= CENTER;
            r_cnt       <= '0;
            leds        <= onehot(CENTER);
            playerPoint <= 1'b0;
            cpuPoint    <= 1'b0;
            playerScore <= 3'd0;
            cpuScore    <= 3'd0;
            gameOver    <= 1'b0;
            winner      <= 1'b0;
        end else begin
            playerPoint <= 1'b0;
            cpuPoint    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_PLAY;
                end
                S_PLAY: begin
                    if (w_p_pt || w_c_pt) begin
                        r_state <= S_POINT;
                        leds    <= '0;
                        if (w_p_pt) begin
                            playerPoint <= 1'b1;
                            if (playerScore < WIN) playerScore <= playerScore + 3'd1;
                        end else begin
                            cpuPoint <= 1'b1;
                            if (cpuScore < WIN) cpuScore <= cpuScore + 3'd1;
                        end
                    end else begin
                        r_pos <= w_pos_next;
                        leds  <= onehot(w_pos_next);
                    end
                end
                S_POINT: begin
                    if (playerScore == WIN || cpuScore == WIN) begin
                        r_state  <= S_GAMEOVER;
                        gameOver <= 1'b1;
                        winner   <= (playerScore == WIN);
                    end else begin
                        r_state <= S_PAUSE;
                        r_cnt   <= '0;
                    end
                end
                S_PAUSE: begin
                    if (r_cnt == CNT_END) begin
                        r_state <= S_PLAY;
                        r_pos   <= CENTER;
                        leds    <= onehot(CENTER);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_GAMEOVER: begin
                    r_state <= S_GAMEOVER;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tug_match_ctrl.sv
// Bench for tug_match_ctrl: directed scenarios plus randomized play against a behavioural match model.
module tb_tug_match_ctrl;
    localparam int NL = 9;
    localparam int WT = 7;
    localparam int PC = 4;
    localparam int CENTER = (NL - 1) / 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          playerKey = 1'b0;
    logic          cpuPress = 1'b0;
    logic [8:0]    difficulty = 9'd0;
    logic [NL-1:0] leds;
    logic          playerPoint, cpuPoint, gameOver, winner;
    logic [2:0]    playerScore, cpuScore;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    tug_match_ctrl #(.NUM_LIGHTS(NL), .WIN_TARGET(WT), .PAUSE_CYCLES(PC)) dut (
        .clk(clk), .hardReset_n(rst_n), .start(start), .playerKey(playerKey),
        .cpuPress(cpuPress), .difficulty(difficulty), .leds(leds),
        .playerPoint(playerPoint), .cpuPoint(cpuPoint), .playerScore(playerScore),
        .cpuScore(cpuScore), .gameOver(gameOver), .winner(winner)
    );

    always #5 clk = ~clk;

    // Behavioural match model: position, scores, remaining dark cycles, key sample history.
    int       m_pos = CENTER, m_ps = 0, m_cs = 0, m_dark = 0;
    bit       m_over = 0, m_winner = 0, m_started = 0, m_pend = 0, m_last_p = 0;
    bit       m_ppulse = 0, m_cpulse = 0;
    bit [2:0] m_hist = 3'b000;
    bit [9:0] m_lfsr = 10'h001;

    task automatic model_reset();
        m_pos = CENTER; m_ps = 0; m_cs = 0; m_dark = 0;
        m_over = 0; m_winner = 0; m_started = 0; m_pend = 0; m_last_p = 0;
        m_ppulse = 0; m_cpulse = 0; m_hist = 3'b000; m_lfsr = 10'h001;
    endtask

    task automatic model_point(input bit player);
        m_last_p = player;
        if (player) begin
            m_ppulse = 1;
            if (m_ps < WT) m_ps++;
            if (m_ps == WT) m_pend = 1;
        end else begin
            m_cpulse = 1;
            if (m_cs < WT) m_cs++;
            if (m_cs == WT) m_pend = 1;
        end
        m_dark = PC + 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit pp, pc;
        if (!rst_n) begin
            model_reset();
        end else begin
            pp = m_hist[1] & ~m_hist[2];
`ifdef CPU_LFSR_EN
            pc = (int'(m_lfsr) < int'(difficulty));
            m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
`else
            pc = cpuPress;
`endif
            m_hist = {m_hist[1:0], playerKey};
            m_ppulse = 0;
            m_cpulse = 0;
            if (m_over) begin
            end else if (m_pend) begin
                m_over = 1;
                m_winner = m_last_p;
            end else if (!m_started) begin
                m_started = start;
            end else if (m_dark > 0) begin
                m_dark--;
                if (m_dark == 0) m_pos = CENTER;
            end else if (pp && !pc) begin
                if (m_pos == 0) model_point(1);
                else m_pos--;
            end else if (pc && !pp) begin
                if (m_pos == NL - 1) model_point(0);
                else m_pos++;
            end
        end
    end

    function automatic logic [NL-1:0] exp_leds();
        logic [NL-1:0] one;
        one = 1;
        if (m_over || m_dark > 0) return '0;
        return one << m_pos;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_leds", leds, exp_leds());
            chk("model_playerPoint", playerPoint, m_ppulse);
            chk("model_cpuPoint", cpuPoint, m_cpulse);
            chk("model_playerScore", playerScore, m_ps);
            chk("model_cpuScore", cpuScore, m_cs);
            chk("model_gameOver", gameOver, m_over);
            chk("model_winner", winner, m_winner);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick(2);
        rst_n = 1'b1; tick(1);
    endtask

    initial begin
        int cyc;
        tick(1);
        cmp_en = 1'b1;
        tick(1);
        chk("reset_leds", leds, 9'b000010000);
        chk("reset_scores", {playerScore, cpuScore}, 6'd0);
        chk("reset_gameOver", gameOver, 1'b0);
        rst_n = 1'b1; tick(1);
        start = 1'b1; tick(1); start = 1'b0;
        chk("start_leds", leds, 9'b000010000);

`ifndef CPU_LFSR_EN
        for (int i = 0; i < 4; i++) begin
            cpuPress = 1'b1; tick(1); cpuPress = 1'b0; tick(1);
        end
        chk("cpu_pos8", leds, 9'b100000000);
        cpuPress = 1'b1; tick(1); cpuPress = 1'b0;
        chk("cpu_point_pulse", cpuPoint, 1'b1);
        chk("cpu_score1", cpuScore, 3'd1);
        chk("cpu_point_dark", leds, '0);
        tick(PC);
        chk("pause_dark", leds, '0);
        tick(1);
        chk("recentre", leds, 9'b000010000);
`endif

        playerKey = 1'b1; tick(1);
        chk("key_edgeN", leds, 9'b000010000);
        tick(1);
        chk("key_edgeN1", leds, 9'b000010000);
        tick(1);
        chk("key_edgeN2", leds, 9'b000001000);
        tick(7);
        chk("key_held", leds, 9'b000001000);
        playerKey = 1'b0; tick(2);
        playerKey = 1'b1; tick(3);
        chk("key_second", leds, 9'b000000100);
        playerKey = 1'b0; tick(3);

`ifndef CPU_LFSR_EN
        for (int i = 0; i < 2; i++) begin
            cpuPress = 1'b1; tick(1); cpuPress = 1'b0; tick(1);
        end
        playerKey = 1'b1; tick(2);
        cpuPress = 1'b1; tick(1); cpuPress = 1'b0;
        chk("tie_pos", leds, 9'b000010000);
        chk("tie_nopoint", {playerPoint, cpuPoint}, 2'b00);
        playerKey = 1'b0; tick(3);
`endif

        // Seven player points to game over.
        do_reset();
        start = 1'b1; tick(1); start = 1'b0;
        cyc = 0;
        while (!gameOver && cyc < 800) begin
            playerKey = ~playerKey;
            tick(2);
            cyc++;
        end
        chk("gameover_reached", (cyc < 800), 1'b1);
        chk("go_playerScore", playerScore, 3'd7);
        chk("go_flags", {gameOver, winner}, 2'b11);
        chk("go_leds", leds, '0);
        for (int i = 0; i < 20; i++) begin
            playerKey = $urandom_range(0, 1);
            cpuPress = $urandom_range(0, 1);
            start = $urandom_range(0, 1);
            tick(1);
        end
        cpuPress = 1'b0; start = 1'b0; playerKey = 1'b0;
        chk("go_held", {gameOver, winner, playerScore, cpuScore}, {2'b11, 3'd7, 3'(m_cs)});
        rst_n = 1'b0; #1;
        chk("async_reset_leds", leds, 9'b000010000);
        chk("async_reset_state", {gameOver, winner, playerScore, cpuScore}, 8'd0);
        tick(1); rst_n = 1'b1; tick(1);

        // Randomized play with occasional starts, resets and difficulty changes.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) playerKey = ~playerKey;
            cpuPress = ($urandom_range(0, 4) == 0);
            start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 99) == 0) difficulty = 9'($urandom_range(0, 511));
            rst_n = ($urandom_range(0, 599) != 0);
            tick(1);
        end
        rst_n = 1'b1; tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
